// File: rtl/lab3_sched_pkg.sv
// rtl/lab3_sched_pkg.sv - shared types and constants for the NAND3/NOR3 mux scheduler
package lab3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic REQ_NAND  = 1'b0;
    localparam logic REQ_NOR   = 1'b1;
    localparam int   DWELL_DEF = 2;

    // Value the datapath MUX is expected to present for a given select and operand buses
    function automatic logic dp_expect(input logic sel, input logic [2:0] nand_in,
                                       input logic [2:0] nor_in);
        return sel ? ~|nor_in : ~&nand_in;
    endfunction

endpackage

// File: rtl/lab3_mux_scheduler_rr_arb2.sv
// rtl/lab3_mux_scheduler_rr_arb2.sv - combinational 2-way round-robin arbiter
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic w_idx;

    // Lone requester wins outright; on a tie the pointer picks the winner
    always_comb begin
        w_idx     = (i_req == 2'b11) ? i_ptr : i_req[1];
        o_gnt_idx = w_idx;
        o_gnt     = 2'b00;
        if (i_en && (|i_req)) begin
            o_gnt = w_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/lab3_mux_scheduler.sv
// rtl/lab3_mux_scheduler.sv - round-robin scheduler sharing the NAND3/NOR3 mux datapath; optional checker under LAB3_SCHED_CHECK_EN
module lab3_mux_scheduler
    import lab3_sched_pkg::*;
#(
    parameter int DWELL = DWELL_DEF,
    parameter int CNT_W = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic [2:0] i_opa0,
    input  logic       i_req1,
    input  logic [2:0] i_opb1,
    output logic       o_ack0,
    output logic       o_ack1,
    output logic       o_res,
    output logic       o_busy,
    output logic [2:0] o_dp_nand_in,
    output logic [2:0] o_dp_nor_in,
    output logic       o_dp_sel,
    input  logic       i_dp_o2
`ifdef LAB3_SCHED_CHECK_EN
    ,
    output logic       o_err
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [2:0]       r_nand;
    logic [2:0]       r_nor;
    logic             r_res;
    logic [1:0]       w_gnt;
    logic             w_gnt_idx;
    logic             w_idle;

    assign w_idle = (r_state == IDLE);

    rr_arb2 u_arb (
        .i_req     ({i_req1, i_req0}),
        .i_ptr     (r_ptr),
        .i_en      (w_idle),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        o_ack0      = 1'b0;
        o_ack1      = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (|w_gnt) begin
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                o_ack0      = (r_sel == REQ_NAND);
                o_ack1      = (r_sel == REQ_NOR);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch at grant, dwell countdown, result capture and pointer hand-off
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr  <= REQ_NAND;
            r_cnt  <= '0;
            r_sel  <= 1'b0;
            r_nand <= 3'b000;
            r_nor  <= 3'b000;
            r_res  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_sel <= w_gnt_idx;
                        r_cnt <= CNT_W'(DWELL - 1);
                        if (w_gnt_idx == REQ_NAND) begin
                            r_nand <= i_opa0;
                        end else begin
                            r_nor <= i_opb1;
                        end
                    end
                end
                DRIVE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                SAMPLE: begin
                    r_res <= i_dp_o2;
                end
                RESP: begin
                    r_ptr <= ~r_sel;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LAB3_SCHED_CHECK_EN
    logic r_err;

    // Sticky flag when the sampled mux output disagrees with the operand-derived value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == SAMPLE) && (i_dp_o2 != dp_expect(r_sel, r_nand, r_nor))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

    assign o_res        = r_res;
    assign o_dp_sel     = r_sel;
    assign o_dp_nand_in = r_nand;
    assign o_dp_nor_in  = r_nor;

endmodule

// File: tb/tb_lab3_mux_scheduler.sv
// tb/tb_lab3_mux_scheduler.sv - self-checking bench for lab3_mux_scheduler
module tb_lab3_mux_scheduler;

    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [2:0] opa0, opb1;
    logic       ack0, ack1, res, busy, dp_sel, dp_o2;
    logic [2:0] dp_nand, dp_nor;
    logic       inj;
`ifdef LAB3_SCHED_CHECK_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    // Datapath stand-in, optionally corrupted
    assign dp_o2 = (dp_sel ? ~|dp_nor : ~&dp_nand) ^ inj;

    lab3_mux_scheduler #(.DWELL(DWELL), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0       (req0),
        .i_opa0       (opa0),
        .i_req1       (req1),
        .i_opb1       (opb1),
        .o_ack0       (ack0),
        .o_ack1       (ack1),
        .o_res        (res),
        .o_busy       (busy),
        .o_dp_nand_in (dp_nand),
        .o_dp_nor_in  (dp_nor),
        .o_dp_sel     (dp_sel),
        .i_dp_o2      (dp_o2)
`ifdef LAB3_SCHED_CHECK_EN
        ,
        .o_err        (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: one transaction timeline at a time
    int         cur = 0;
    bit         m_active = 0;
    int         m_t = 0;
    bit         m_g = 0;
    logic [2:0] m_op = 0;
    bit         m_ptr = 0;
    bit         m_res = 0;
    bit         m_sel = 0;
    logic [2:0] m_nand = 0;
    logic [2:0] m_nor = 0;
    bit         m_err = 0;

    function automatic bit op_fn(input bit sel, input logic [2:0] op);
        return sel ? ~|op : ~&op;
    endfunction

    function automatic bit exp_ack(input bit n);
        return m_active && (cur == m_t + DWELL + 2) && (m_g == n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_active = 0; m_ptr = 0; m_res = 0; m_sel = 0;
            m_nand = 0; m_nor = 0; m_err = 0;
        end else if (m_active) begin
            if (cur == m_t + DWELL + 1) begin
                m_res = op_fn(m_g, m_op) ^ inj;
                if (inj) m_err = 1;
            end
            if (cur == m_t + DWELL + 2) begin
                m_active = 0;
                m_ptr    = ~m_g;
            end
        end else if (req0 || req1) begin
            m_g      = (req0 && req1) ? m_ptr : req1;
            m_t      = cur;
            m_active = 1;
            m_op     = m_g ? opb1 : opa0;
            m_sel    = m_g;
            if (m_g) m_nor = m_op;
            else     m_nand = m_op;
        end
    endtask

    task automatic check_all();
        chk("busy", busy, m_active);
        chk("ack0", ack0, exp_ack(0));
        chk("ack1", ack1, exp_ack(1));
        chk("res", res, m_res);
        chk("dp_sel", dp_sel, m_sel);
        chk("dp_nand", dp_nand, m_nand);
        chk("dp_nor", dp_nor, m_nor);
`ifdef LAB3_SCHED_CHECK_EN
        chk("err", err, m_err);
`endif
    endtask

    // Inputs for the current cycle are already driven; advance one clock and compare
    task automatic tick();
        model_step();
        @(posedge clk);
        cur++;
        #1;
        check_all();
    endtask

    task automatic run_to_ack(output int n, output bit idx);
        bit found;
        found = 0;
        n = 0;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                tick();
                n++;
                if (ack0 || ack1) begin
                    found = 1;
                    idx = ack1;
                end
            end
        end
        if (!found) n = -1;
    endtask

    typedef struct {
        bit         r0;
        logic [2:0] a0;
        bit         r1;
        logic [2:0] b1;
        bit         e_idx;
        bit         e_res;
        logic [2:0] e_bus;
    } vec_t;

    vec_t vecs[8];
    int   ack_cyc[$];
    bit   ack_idx[$];
    int   n;
    bit   idx;
    bit   pend0, pend1;

    initial begin
        rst_n = 0; req0 = 1; opa0 = 3'b111; req1 = 0; opb1 = 3'b000; inj = 0;

        // Reset held two cycles with a request pending
        tick();
        tick();
        chk("rst_ack0", ack0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nand", dp_nand, 3'b000);
        rst_n = 1;
        run_to_ack(n, idx);
        chk("rst_first_lat", n, DWELL + 2);
        chk("rst_first_idx", idx, 0);
        req0 = 0;
        tick();

        // Single transactions from idle; pointer starts at 1 here
        vecs[0] = '{1, 3'b111, 0, 3'b000, 0, 0, 3'b111};
        vecs[1] = '{1, 3'b101, 0, 3'b000, 0, 1, 3'b101};
        vecs[2] = '{0, 3'b000, 1, 3'b000, 1, 1, 3'b000};
        vecs[3] = '{0, 3'b000, 1, 3'b010, 1, 0, 3'b010};
        vecs[4] = '{1, 3'b011, 1, 3'b100, 0, 1, 3'b011};
        vecs[5] = '{1, 3'b111, 1, 3'b000, 1, 1, 3'b000};
        vecs[6] = '{1, 3'b000, 0, 3'b110, 0, 1, 3'b000};
        vecs[7] = '{0, 3'b001, 1, 3'b111, 1, 0, 3'b111};
        // vecs[4] expects pointer 0: vecs[3] was a NOR grant
        for (int v = 0; v < 8; v++) begin
            req0 = vecs[v].r0; opa0 = vecs[v].a0;
            req1 = vecs[v].r1; opb1 = vecs[v].b1;
            run_to_ack(n, idx);
            chk($sformatf("v%0d_lat", v), n, DWELL + 2);
            chk($sformatf("v%0d_idx", v), idx, vecs[v].e_idx);
            chk($sformatf("v%0d_res", v), res, vecs[v].e_res);
            chk($sformatf("v%0d_sel", v), dp_sel, vecs[v].e_idx);
            chk($sformatf("v%0d_bus", v), vecs[v].e_idx ? dp_nor : dp_nand, vecs[v].e_bus);
            req0 = 0; req1 = 0;
            tick();
        end

        // Contention from reset: alternating grants spaced DWELL+3
        rst_n = 0;
        tick();
        rst_n = 1; req0 = 1; req1 = 1; opa0 = 3'b110; opb1 = 3'b001;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (ack0 || ack1) begin
                ack_cyc.push_back(cur);
                ack_idx.push_back(ack1);
            end
        end
        chk("cont_count", ack_cyc.size(), 4);
        for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
            chk($sformatf("cont_idx%0d", i), ack_idx[i], i % 2);
            if (i > 0) chk($sformatf("cont_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], DWELL + 3);
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < DWELL + 3; i++) tick();

        // Reset mid-transaction restores pointer 0
        req0 = 1; opa0 = 3'b010;
        run_to_ack(n, idx);
        req0 = 0;
        tick();
        req1 = 1; opb1 = 3'b000;
        tick();
        req1 = 0;
        tick();
        rst_n = 0;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_sel", dp_sel, 0);
        chk("mid_ack1", ack1, 0);
        rst_n = 1; req0 = 1; req1 = 1; opa0 = 3'b001; opb1 = 3'b011;
        run_to_ack(n, idx);
        chk("mid_ptr_idx", idx, 0);
        req0 = 0; req1 = 0;
        tick();

        // Randomized traffic against the reference
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 1500; c++) begin
            if (exp_ack(0)) pend0 = 0;
            if (exp_ack(1)) pend1 = 0;
            if (!pend0) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend0 = 1; req0 = 1; opa0 = 3'($urandom_range(0, 7));
                end else req0 = 0;
            end else if (m_active && m_g == 0 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) req0 = 0;
                opa0 = 3'($urandom_range(0, 7));
            end
            if (!pend1) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend1 = 1; req1 = 1; opb1 = 3'($urandom_range(0, 7));
                end else req1 = 0;
            end else if (m_active && m_g == 1 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) req1 = 0;
                opb1 = 3'($urandom_range(0, 7));
            end
            tick();
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < DWELL + 4; i++) tick();

`ifdef LAB3_SCHED_CHECK_EN
        // Corrupted datapath during one transaction sets a sticky error
        inj = 1; req0 = 1; opa0 = 3'b100;
        run_to_ack(n, idx);
        chk("chk_err_set", err, 1);
        inj = 0; req0 = 0;
        tick();
        req1 = 1; opb1 = 3'b000;
        run_to_ack(n, idx);
        chk("chk_err_sticky", err, 1);
        req1 = 0;
        rst_n = 0;
        tick();
        chk("chk_err_clr", err, 0);
        rst_n = 1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab3_mux_scheduler.md
Name: lab3_mux_scheduler

Overview:
- Controller that shares the NAND3/NOR3 + 2:1 MUX datapath between two requesters.
- Requester 0 needs NAND3 results (SEL=0); requester 1 needs NOR3 results (SEL=1).
- Round-robin arbitration; drives the datapath operands and select; waits a settle window; samples the MUX output; returns it with a one-cycle ACK.
- Sits between the requester logic and the combinational datapath instance.

Parameters:
- DWELL, 2, settle cycles with operands/select stable before sampling; legal range 1..15.
- CNT_W, 4, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- REQ0  in  1  requester 0 request (NAND3).
- OPA0  in  3  requester 0 operand; valid while REQ0=1.
- REQ1  in  1  requester 1 request (NOR3).
- OPB1  in  3  requester 1 operand; valid while REQ1=1.
- ACK0  out  1  one-cycle completion pulse to requester 0.
- ACK1  out  1  one-cycle completion pulse to requester 1.
- RES  out  1  sampled result; valid in ACK cycle, held until next ACK.
- BUSY  out  1  high in any state other than IDLE.
- DP_NAND_IN  out  3  datapath I0..I2.
- DP_NOR_IN  out  3  datapath I3..I5.
- DP_SEL  out  1  datapath SEL0.
- DP_O2  in  1  datapath MUX output.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state=IDLE, priority pointer=0.
  - ACK0, ACK1, RES, BUSY, DP_SEL = 0; DP_NAND_IN, DP_NOR_IN = 3'b000.
  - Reset in any state aborts the transaction; no ACK is issued.
- States: IDLE, DRIVE, SAMPLE, RESP.
- IDLE:
  - If neither REQ is high, stay.
  - If exactly one REQ is high, grant it.
  - If both are high, grant the pointer's requester.
  - On grant, register the granted operand into the matching DP_* bus: OPA0 to DP_NAND_IN, or OPB1 to DP_NOR_IN. The other bus holds its last value.
  - On grant, set DP_SEL = granted index, load counter = DWELL-1, go to DRIVE.
- DRIVE:
  - DP_* buses stable; decrement counter.
  - At counter==0, go to SAMPLE. DRIVE lasts exactly DWELL cycles.
- SAMPLE: RES <= DP_O2; go to RESP.
- RESP:
  - ACKn=1 for the granted requester only, for exactly one cycle.
  - Pointer <= other requester.
  - Go to IDLE.
- Latency: grant at IDLE cycle t; ACK in cycle t+DWELL+2; next grant possible at t+DWELL+3.
- Handshake:
  - Requester holds REQ and operand stable until ACK is seen.
  - Requester deasserts REQ no later than the cycle after ACK; a REQ still high in that IDLE cycle is a new request.
  - REQ dropped mid-transaction does not abort it; the ACK is still issued.
- Operand changes after grant are ignored (operand latched at grant).
- DP_SEL and DP_* hold their values through IDLE. There is no return-to-zero, so no spurious select toggles.
- BUSY=1 in DRIVE, SAMPLE and RESP.
- Fairness: with both REQ held continuously, grants alternate 0,1,0,1,...
- Starvation bound: at most one foreign transaction between a request and its grant.

Optional Feature:
- Macro: LAB3_SCHED_CHECK_EN.
- When defined:
  - In SAMPLE, compare DP_O2 to the internally computed expected value: ~&operand when SEL=0, ~|operand when SEL=1.
  - On mismatch, set sticky output ERR (1 bit, added to the port list); cleared only by reset.
- When undefined: no ERR port and no checker logic.

Decomposition:
- Package lab3_sched_pkg:
  - state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, RESP=2'd3).
  - requester index constants REQ_NAND=1'b0, REQ_NOR=1'b1.
  - DWELL default constant.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], ptr, en.
  - Outputs: gnt[1:0], gnt_idx. Purely combinational.
  - Pointer register stays in the parent.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with REQ0=1 -> all outputs 0, no ACK; after release, grant in first IDLE cycle, ACK0 at t+4 (DWELL=2).
- Single NAND: REQ0=1, OPA0=3'b111 -> DP_SEL=0, DP_NAND_IN=111, ACK0 pulse 1 cycle, RES=0; OPA0=3'b101 -> RES=1.
- Single NOR: REQ1=1, OPB1=3'b000 -> DP_SEL=1, ACK1, RES=1; OPB1=3'b010 -> RES=0; ACK0 never asserted.
- Contention: REQ0=REQ1=1 held for 4 transactions from reset -> ACK order 0,1,0,1; each ACK spaced DWELL+3=5 cycles.
- Reset mid-op: RST_N=0 during DRIVE -> no ACK, BUSY=0 next cycle, pointer=0, DP_SEL=0.
- Checker (LAB3_SCHED_CHECK_EN): force DP_O2 inverted from the model for one transaction -> ERR=1 from SAMPLE+1 onward, persisting until reset.
